// File: rtl/input_port_pkg.sv
// Shared types and sizing helpers for the CPMath input stage.
package cpmath_io_pkg;

    // Operand-capture FSM states.
    typedef enum logic [1:0] {
        ARM      = 2'd0,
        IDLE     = 2'd1,
        HOLD     = 2'd2,
        WAIT_REL = 2'd3
    } io_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int DEBOUNCE_CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/input_port_if.sv
// Operand handshake between the input stage (master) and the control unit (slave).
interface input_port_if;
    logic        in_req;
    logic        in_ack;
    logic        in_valid;
    logic [31:0] in_data;

    modport master (
        input  in_req,
        input  in_ack,
        output in_valid,
        output in_data
    );

    modport slave (
        output in_req,
        output in_ack,
        input  in_valid,
        input  in_data
    );
endinterface

// File: rtl/input_port_sync_debounce.sv
// Button conditioning: 2-flop synchroniser, active-high normalisation and
// a consecutive-mismatch debounce counter driving the debounced level.
module sync_debounce
    import cpmath_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic btn_n_o,
    output logic pressed_o,
    output logic toggle_o
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            REL_LVL  = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             btn_n;
    logic             toggle;

    // Synchroniser comes out of reset at the released level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= REL_LVL;
            s2_q <= REL_LVL;
        end else begin
            s1_q <= btn_raw_i;
            s2_q <= s1_q;
        end
    end

    assign btn_n = ACTIVE_LOW ? ~s2_q : s2_q;

    // Toggle fires on the edge that completes a full window of mismatches,
    // so the consumer can act on the same edge that updates pressed.
    always_comb begin
        toggle    = 1'b0;
        cnt_d     = '0;
        pressed_d = pressed_q;
        if (btn_n != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                toggle    = 1'b1;
                pressed_d = ~pressed_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce counter and accepted level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
        end
    end

    assign btn_n_o   = btn_n;
    assign pressed_o = pressed_q;
    assign toggle_o  = toggle;

endmodule

// File: rtl/input_port.sv
// Input stage for the CPMath `input` instruction: synchronises the switch
// bank, debounces the enter button and hands one operand per press to the
// control unit under a valid/ack handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARM      | after reset; waits for a confirmed, stable released button
// IDLE     | ready; a rising press captures if in_req, else is skipped
// HOLD     | operand captured and valid; leaves on in_ack
// WAIT_REL | press already handled; waits for the debounced release
module input_port
    import cpmath_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  switch,
    input  logic         btn_enter,
    input_port_if.master io,
    output logic         overrun,
    output logic         pressed
);

    // ARM needs extra edges on its first window so the synchroniser's
    // reset value cannot pass for a released button held through reset.
    localparam int               ARM_W      = cnt_width(DEBOUNCE_CYCLES + 2);
    localparam logic [ARM_W-1:0] ARM_INIT   = ARM_W'(DEBOUNCE_CYCLES + 2);
    localparam logic [ARM_W-1:0] ARM_RELOAD = ARM_W'(DEBOUNCE_CYCLES);

    logic [15:0]      sw_s1_q, sw_s2_q;
    logic             btn_n;
    logic             btn_tgl;
    logic             pressed_w;
    logic             rise, fall, pressed_nxt;
    logic             ack;
    logic             clean;

    io_state_e        state_q, state_d;
    logic             valid_q, valid_d;
    logic [31:0]      data_q, data_d;
    logic             overrun_q, overrun_d;
    logic             pend_q, pend_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_btn (
        .clk       (clk),
        .reset     (reset),
        .btn_raw_i (btn_enter),
        .btn_n_o   (btn_n),
        .pressed_o (pressed_w),
        .toggle_o  (btn_tgl)
    );

    // Plain 2-flop synchroniser for the switch bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= switch;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign rise        = btn_tgl & ~pressed_w;
    assign fall        = btn_tgl &  pressed_w;
    assign pressed_nxt = pressed_w ^ btn_tgl;
    assign ack         = io.in_ack & valid_q;
    assign clean       = ~btn_n & ~pressed_w;

    // Next-state and handshake logic; ack is honoured in every state and
    // takes priority over a press confirmed on the same edge.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q & ~io.in_ack;
        data_d    = data_q;
        overrun_d = overrun_q | (rise & valid_q & ~ack);
        pend_d    = 1'b0;
        arm_cnt_d = arm_cnt_q;

        case (state_q)
            ARM: begin
                if (!clean) begin
                    arm_cnt_d = ARM_RELOAD;
                end else if (arm_cnt_q == ARM_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q - ARM_W'(1);
                end
            end
            IDLE: begin
                // pend_q replays a press that arrived on an ack edge in HOLD.
                if ((rise || pend_q) && !valid_q) begin
                    if (io.in_req) begin
                        data_d  = {16'b0, sw_s2_q};
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = pressed_nxt ? WAIT_REL : IDLE;
                    end
                end
            end
            HOLD: begin
                if (ack) begin
                    if (rise) begin
                        pend_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = pressed_nxt ? WAIT_REL : IDLE;
                    end
                end
            end
            WAIT_REL: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = ARM;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, handshake and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            pend_q    <= 1'b0;
            arm_cnt_q <= ARM_INIT;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            pend_q    <= pend_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign io.in_valid = valid_q;
    assign io.in_data  = data_q;
    assign overrun     = overrun_q;
    assign pressed     = pressed_w;

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port: a table of press scenarios plus
// hand-written sequences for reset, latency, ack/press collisions.
module tb_input_port;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic        btn;
    logic        overrun;
    logic        pressed;

    int n_cmp;
    int n_bad;

    input_port_if bus ();

    input_port #(
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .switch    (sw),
        .btn_enter (btn),
        .io        (bus),
        .overrun   (overrun),
        .pressed   (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sw;
        logic        req;
        int          hold;
        logic        ack_after;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_ovr;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Button is active-low: 0 = pressed.
    task automatic press_seq(input logic [15:0] s, input logic r, input int hold, input int rel);
        sw         = s;
        bus.in_req = r;
        btn        = 1'b0;
        cyc(hold);
        btn        = 1'b1;
        cyc(rel);
    endtask

    task automatic ack_pulse();
        bus.in_ack = 1'b1;
        cyc(1);
        bus.in_ack = 1'b0;
    endtask

    initial begin
        int   rises;
        logic prev;

        n_cmp = 0;
        n_bad = 0;

        tbl[0] = '{16'h0007, 1'b1, 3, 1'b0, 1'b0, 32'h0000_000C, 1'b0};
        tbl[1] = '{16'hBEEF, 1'b1, 4, 1'b1, 1'b1, 32'h0000_BEEF, 1'b0};
        tbl[2] = '{16'h0033, 1'b0, 8, 1'b0, 1'b0, 32'h0000_BEEF, 1'b0};
        tbl[3] = '{16'h0005, 1'b1, 8, 1'b0, 1'b1, 32'h0000_0005, 1'b0};
        tbl[4] = '{16'h0009, 1'b1, 8, 1'b1, 1'b1, 32'h0000_0005, 1'b1};

        // Reset with the button held down.
        rst_n      = 1'b0;
        btn        = 1'b0;
        sw         = 16'h0;
        bus.in_req = 1'b0;
        bus.in_ack = 1'b0;
        cyc(3);
        chk("rst_valid",   bus.in_valid, 1'b0);
        chk("rst_data",    bus.in_data,  32'h0);
        chk("rst_overrun", overrun,      1'b0);
        chk("rst_pressed", pressed,      1'b0);

        rst_n      = 1'b1;
        bus.in_req = 1'b1;
        cyc(20);
        chk("held_pressed",  pressed,      1'b1);
        chk("held_no_capt",  bus.in_valid, 1'b0);
        btn = 1'b1;
        cyc(10);

        // First real press: in_valid rises after the 6th edge (E5).
        sw  = 16'd123;
        btn = 1'b0;
        cyc(5);
        chk("lat_before_valid", bus.in_valid, 1'b0);
        chk("lat_before_press", pressed,      1'b0);
        cyc(1);
        chk("lat_valid",   bus.in_valid, 1'b1);
        chk("lat_pressed", pressed,      1'b1);
        chk("lat_data",    bus.in_data,  32'd123);
        cyc(2);
        btn = 1'b1;
        cyc(10);
        chk("hold_valid", bus.in_valid, 1'b1);
        ack_pulse();
        chk("ack_valid",  bus.in_valid, 1'b0);
        chk("ack_keep",   bus.in_data,  32'd123);

        // Ack on the same edge that confirms a new press.
        press_seq(16'h0011, 1'b1, 8, 10);
        chk("coll_pre_valid", bus.in_valid, 1'b1);
        chk("coll_pre_data",  bus.in_data,  32'h11);
        sw  = 16'h0022;
        btn = 1'b0;
        cyc(5);
        bus.in_ack = 1'b1;
        cyc(1);
        bus.in_ack = 1'b0;
        chk("coll_valid",   bus.in_valid, 1'b0);
        chk("coll_overrun", overrun,      1'b0);
        chk("coll_data",    bus.in_data,  32'h11);
        cyc(1);
        chk("coll_recap_valid", bus.in_valid, 1'b1);
        chk("coll_recap_data",  bus.in_data,  32'h22);
        chk("coll_recap_ovr",   overrun,      1'b0);
        cyc(3);
        btn = 1'b1;
        cyc(10);
        ack_pulse();
        chk("coll_ack", bus.in_valid, 1'b0);

        // Long hold with an ack mid-way: one capture only.
        sw         = 16'h00AA;
        bus.in_req = 1'b1;
        btn        = 1'b0;
        rises      = 0;
        prev       = bus.in_valid;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.in_valid && !prev) rises++;
            prev = bus.in_valid;
            if (i == 19) bus.in_ack = 1'b1;
            if (i == 20) begin
                bus.in_ack = 1'b0;
                chk("long_ack_edge", bus.in_valid, 1'b0);
            end
        end
        chk("long_one_capture", rises,        1);
        chk("long_valid_low",   bus.in_valid, 1'b0);
        btn = 1'b1;
        cyc(10);
        chk("long_no_repeat", bus.in_valid, 1'b0);
        press_seq(16'h00AB, 1'b1, 8, 10);
        chk("long_repress_valid", bus.in_valid, 1'b1);
        chk("long_repress_data",  bus.in_data,  32'hAB);
        ack_pulse();

        // Press while in_req is low; raising it late must not capture.
        bus.in_req = 1'b0;
        sw         = 16'h000C;
        btn        = 1'b0;
        cyc(8);
        bus.in_req = 1'b1;
        cyc(10);
        chk("req_late_held", bus.in_valid, 1'b0);
        btn = 1'b1;
        cyc(10);
        chk("req_late_rel", bus.in_valid, 1'b0);
        press_seq(16'h000C, 1'b1, 8, 10);
        chk("req_repress_valid", bus.in_valid, 1'b1);
        chk("req_repress_data",  bus.in_data,  32'h0C);
        ack_pulse();

        // Ack with nothing valid is ignored.
        ack_pulse();
        chk("idle_ack_valid", bus.in_valid, 1'b0);
        chk("idle_ack_data",  bus.in_data,  32'h0C);
        chk("idle_ack_ovr",   overrun,      1'b0);

        // Table of press scenarios: glitch, min-length press, gated press, overrun.
        for (int k = 0; k < 5; k++) begin
            press_seq(tbl[k].sw, tbl[k].req, tbl[k].hold, 10);
            chk($sformatf("v%0d_valid",   k), bus.in_valid, tbl[k].exp_valid);
            chk($sformatf("v%0d_data",    k), bus.in_data,  tbl[k].exp_data);
            chk($sformatf("v%0d_overrun", k), overrun,      tbl[k].exp_ovr);
            chk($sformatf("v%0d_pressed", k), pressed,      1'b0);
            if (tbl[k].ack_after) begin
                ack_pulse();
                chk($sformatf("v%0d_ack_valid",   k), bus.in_valid, 1'b0);
                chk($sformatf("v%0d_ack_overrun", k), overrun,      tbl[k].exp_ovr);
            end
        end

        // Asynchronous reset mid-handshake.
        press_seq(16'h0044, 1'b1, 8, 10);
        chk("pre_rst_valid", bus.in_valid, 1'b1);
        chk("pre_rst_data",  bus.in_data,  32'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.in_valid, 1'b0);
        chk("async_rst_data",  bus.in_data,  32'h0);
        chk("async_rst_ovr",   overrun,      1'b0);
        cyc(2);
        rst_n = 1'b1;
        sw    = 16'h0055;
        btn   = 1'b0;
        cyc(12);
        chk("arm_pressed",  pressed,      1'b1);
        chk("arm_no_capt",  bus.in_valid, 1'b0);
        btn = 1'b1;
        cyc(14);
        press_seq(16'h0066, 1'b1, 8, 10);
        chk("post_rst_valid", bus.in_valid, 1'b1);
        chk("post_rst_data",  bus.in_data,  32'h66);
        chk("post_rst_ovr",   overrun,      1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
